// File: rtl/voice_mixer_if.sv
// voice_mixer_if: bundles the frame clock, voice samples, gain and the mixed
// sample outputs of voice_mixer. The mixer takes the slave modport; whoever
// supplies voices and consumes the sample takes the master modport.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 4
);
  logic                      lrck;
  logic [16*NUM_VOICES-1:0]  voice_in;
  logic [7:0]                master_gain;
  logic [15:0]               sample_out;
  logic                      sample_valid;
  logic                      clip;
  logic [15:0]               peak_bar;

  modport master (
    output lrck, voice_in, master_gain,
    input  sample_out, sample_valid, clip, peak_bar
  );

  modport slave (
    input  lrck, voice_in, master_gain,
    output sample_out, sample_valid, clip, peak_bar
  );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: once per audio frame (rising edge of lrck) snapshot every voice,
// sum them one voice per clock at full precision, scale by a Q1.7 master gain,
// saturate to 16-bit signed and present a registered sample with a one-cycle
// valid pulse.
// Optional feature macro: MIXER_PEAK_METER_EN builds a decaying peak meter that
// drives peak_bar as a thermometer code; without it peak_bar is tied to 0.
module voice_mixer #(
  parameter int NUM_VOICES       = 4,
  parameter int PEAK_DECAY_SHIFT = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  voice_mixer_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = 16 + IDX_W;
  localparam int PROD_W = ACC_W + 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  // Elaboration-time guard on the supported parameter ranges.
  if ((NUM_VOICES < 2) || (NUM_VOICES > 8)) begin : g_bad_voices
    $error("voice_mixer: NUM_VOICES must be 2..8");
  end
  if ((PEAK_DECAY_SHIFT < 1) || (PEAK_DECAY_SHIFT > 14)) begin : g_bad_shift
    $error("voice_mixer: PEAK_DECAY_SHIFT must be 1..14");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;

  logic                     lrck_meta_r;
  logic                     lrck_sync_r;
  logic                     lrck_hist_r;
  logic                     frame_start_s;

  logic                     load_s;
  logic                     accum_s;
  logic                     scale_s;

  logic signed [15:0]       snap_r [NUM_VOICES];
  logic signed [15:0]       snap_cur_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic [IDX_W-1:0]         idx_r;

  logic signed [PROD_W-1:0] acc_ext_s;
  logic signed [PROD_W-1:0] gain_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] shifted_s;
  logic [PROD_W-16:0]       upper_s;
  logic signed [15:0]       sat_s;
  logic                     sat_flag_s;

  logic [15:0]              sample_out_r;
  logic                     sample_valid_r;
  logic                     clip_r;

  // Two-flop synchronizer for lrck plus an edge-history flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lrck_meta_r <= 1'b0;
      lrck_sync_r <= 1'b0;
      lrck_hist_r <= 1'b0;
    end else begin
      lrck_meta_r <= bus.lrck;
      lrck_sync_r <= lrck_meta_r;
      lrck_hist_r <= lrck_sync_r;
    end
  end

  // A rising lrck seen after synchronization marks a new frame.
  assign frame_start_s = lrck_sync_r & ~lrck_hist_r;

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a frame start outside IDLE is dropped, never queued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = SCALE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      SCALE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from the current state.
  always_comb begin
    load_s  = 1'b0;
    accum_s = 1'b0;
    scale_s = 1'b0;
    case (state_r)
      IDLE:    load_s  = frame_start_s;
      ACCUM:   accum_s = 1'b1;
      SCALE:   scale_s = 1'b1;
      default: begin
        load_s  = 1'b0;
        accum_s = 1'b0;
        scale_s = 1'b0;
      end
    endcase
  end

  // Snapshot all voices at frame start so later input changes cannot leak in.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        snap_r[k] <= 16'sd0;
      end
    end else if (load_s) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        snap_r[k] <= bus.voice_in[16*k +: 16];
      end
    end
  end

  assign snap_cur_s = snap_r[idx_r];

  // Full-precision accumulator, one voice per clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (load_s) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (accum_s) begin
      acc_r <= acc_r + {{IDX_W{snap_cur_s[15]}}, snap_cur_s};
      idx_r <= idx_r + IDX_W'(1);
    end
  end

  // Gain, floor shift by 7 and saturation to 16-bit signed.
  always_comb begin
    acc_ext_s  = {{9{acc_r[ACC_W-1]}}, acc_r};
    gain_ext_s = {{(PROD_W-8){1'b0}}, bus.master_gain};
    prod_s     = acc_ext_s * gain_ext_s;
    shifted_s  = prod_s >>> 5'd7;
    upper_s    = shifted_s[PROD_W-1:15];
    if ((&upper_s) | ~(|upper_s)) begin
      sat_s      = shifted_s[15:0];
      sat_flag_s = 1'b0;
    end else if (shifted_s[PROD_W-1]) begin
      sat_s      = 16'sh8000;
      sat_flag_s = 1'b1;
    end else begin
      sat_s      = 16'sh7FFF;
      sat_flag_s = 1'b1;
    end
  end

  // Output sample, clip flag and valid pulse, all updated only in SCALE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sample_out_r   <= 16'h0000;
      sample_valid_r <= 1'b0;
      clip_r         <= 1'b0;
    end else begin
      sample_valid_r <= scale_s;
      if (scale_s) begin
        sample_out_r <= sat_s;
        clip_r       <= sat_flag_s;
      end
    end
  end

  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.clip         = clip_r;

`ifdef MIXER_PEAK_METER_EN
  logic [14:0] peak_r;
  logic [14:0] peak_decay_s;
  logic [14:0] sample_mag_s;
  logic [14:0] peak_next_s;
  logic [15:0] sat_neg_s;
  logic [15:0] bar_next_s;
  logic [15:0] peak_bar_r;

  // Magnitude of the new sample (clamping -32768), decayed peak and bar code.
  always_comb begin
    sat_neg_s = 16'd0 - sat_s;
    if (sat_s == 16'sh8000) begin
      sample_mag_s = 15'h7FFF;
    end else if (sat_s[15]) begin
      sample_mag_s = sat_neg_s[14:0];
    end else begin
      sample_mag_s = sat_s[14:0];
    end
    peak_decay_s = peak_r - (peak_r >> PEAK_DECAY_SHIFT);
    if (sample_mag_s > peak_decay_s) begin
      peak_next_s = sample_mag_s;
    end else begin
      peak_next_s = peak_decay_s;
    end
    for (int i = 0; i < 16; i++) begin
      bar_next_s[i] = (peak_next_s > 15'(i * 2048));
    end
  end

  // Peak and bar graph registers, advanced once per produced sample.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      peak_r     <= 15'd0;
      peak_bar_r <= 16'h0000;
    end else if (scale_s) begin
      peak_r     <= peak_next_s;
      peak_bar_r <= bar_next_s;
    end
  end

  assign bus.peak_bar = peak_bar_r;
`else
  assign bus.peak_bar = 16'h0000;
`endif

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Sequential output mixer between the voice bank and `audio_interface`. Once per audio frame, on the rising edge of `AUD_DACLRCK`, it snapshots all voice samples and accumulates them one voice per cycle at full precision. It then applies a master gain, saturates to 16-bit signed, and presents a registered sample for `LDATA`/`RDATA`. An optional peak meter drives an LEDR bar graph.

## Interface
Parameters:
- `NUM_VOICES`, 4: voices summed; range 2–8.
- `PEAK_DECAY_SHIFT`, 4: peak-meter decay per frame is `peak >> PEAK_DECAY_SHIFT`.

Ports:
- `Clk`  in  1  CLOCK_50 domain clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `lrck`  in  1  `AUD_DACLRCK`, asynchronous to `Clk`.
- `voice_in`  in  16*NUM_VOICES  packed signed voice samples; voice k at `[16k+15:16k]`.
- `master_gain`  in  8  unsigned Q1.7; 0x80 = unity, 0xFF ≈ 1.99.
- `sample_out`  out  16  signed mixed sample.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `clip`  out  1  high when the last produced sample saturated.
- `peak_bar`  out  16  thermometer peak level.

## Operation
- Synchronizer:
  - `lrck` passes through 2 flops, then an edge-history flop.
  - A frame starts when synced = 1 and history = 0.
  - All three flops reset to 0, so `lrck` already high at reset release starts exactly one frame.
- FSM states: IDLE, ACCUM, SCALE.
  - IDLE → ACCUM on frame start: snapshot `voice_in` into internal registers; `acc` = 0; `idx` = 0.
  - ACCUM: `acc += snap[idx]`, `idx++`. Stay for NUM_VOICES cycles, then go to SCALE.
  - SCALE: compute `prod = acc * {1'b0, master_gain}`, then arithmetic shift right 7 (floor). Saturate to [-32768, 32767]. Register the result into `sample_out`, set `clip` = saturated, pulse `sample_valid`, and return to IDLE.
- Widths:
  - `acc` is 16 + clog2(NUM_VOICES) bits signed; no overflow is possible.
  - `prod` is width(acc) + 9 bits signed.
- A frame start detected outside IDLE is ignored, not queued.
- `voice_in` changes after the snapshot do not affect the current frame.
- `clip` holds until the next SCALE.
- Reset mid-frame: the FSM returns to IDLE, no `sample_valid` pulse occurs, and all outputs return to reset values.
- Reset values: `sample_out` = 0, `sample_valid` = 0, `clip` = 0, `peak_bar` = 0, `acc` = 0, `idx` = 0, peak = 0.

## Timing
- `lrck` rising edge → frame start: at most 3 `Clk` edges.
- Frame start (snapshot edge E) → `sample_valid` is high in the cycle following edge E+NUM_VOICES+1.
- For NUM_VOICES = 4, `lrck` edge → `sample_valid` is at most 8 `Clk` cycles.
- `sample_valid` is high for exactly 1 cycle per frame.
- `sample_out` is stable from `sample_valid` until the next frame's SCALE; `audio_interface` samples it asynchronously.
- The frame period (~1040 cycles at 48 kHz) far exceeds the latency, so the ignored-edge case only occurs under bench stress.

## Configuration
- `MIXER_PEAK_METER_EN` defined:
  - A 15-bit magnitude register `peak` updates at each SCALE: `peak = max(peak - (peak >> PEAK_DECAY_SHIFT), |sample_out_next|)`.
  - `|-32768|` is clamped to 32767.
  - `peak_bar[i]` = 1 iff `peak > i*2048`, for i = 0..15.
- Not defined: no peak register is built and `peak_bar` is tied to 0.

## Test plan
- Assert `Reset` with `lrck` toggling → all outputs 0 and no `sample_valid` pulse.
- Four voices = 0x1000, gain 0x80, one `lrck` rise → `sample_out` = 0x4000, `clip` = 0, exactly one `sample_valid` pulse within 8 cycles.
- Saturation:
  - Four voices = 0x7FFF, gain 0x80 → 0x7FFF, `clip` = 1.
  - Four voices = 0x8000 → 0x8000, `clip` = 1.
  - Next frame with all voices 0 → `clip` = 0.
- Gain and rounding:
  - Gain 0x40 with voices 0x0100, 0x0200, 0xFF00, 0x0000 → 0x0100.
  - Gain 0x40 with voices 0xFFFF, 0, 0, 0 → 0xFFFF (floor).
- Snapshot and abort:
  - Change `voice_in` during ACCUM → result reflects the snapshot.
  - Second frame start during ACCUM → ignored.
  - `Reset` mid-ACCUM → no pulse, outputs 0.
- Peak meter (`MIXER_PEAK_METER_EN`):
  - One frame of 0x7FFF → `peak_bar` = 0xFFFF.
  - Then one frame of 0 → peak 30720, `peak_bar` = 0x7FFF.
  - Without the macro, `peak_bar` stays 0.
